// File: rtl/multi_debounce.sv
// Multi-channel push-button debouncer: per-channel synchroniser, saturating stability counter, edge pulses.
// Define MULTI_DEBOUNCE_LONG_PRESS_EN to add the per-channel long-press detector driving long_o.
module multi_debounce #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4000000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        RESET_LEVEL     = 1'b0,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] btn_i,
  output logic [NUM_CH-1:0] btn_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              any_change_o,
  output logic [NUM_CH-1:0] long_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // Reject configurations the synchroniser and counters cannot represent
  if (NUM_CH == 0) begin : g_bad_num_ch
    $error("multi_debounce: NUM_CH must be >= 1");
  end
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("multi_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_debounce: SYNC_STAGES must be >= 2");
  end
  if (LONG_CYCLES == 0) begin : g_bad_long
    $error("multi_debounce: LONG_CYCLES must be >= 1");
  end

  logic [NUM_CH-1:0] btn_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cand_q;
    logic                   cand_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   btn_d;
    logic                   s_c;

    assign s_c = sync_q[SYNC_STAGES-1];

    // A change of the synchronised level restarts the stability count; a saturated count commits it
    always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      btn_d  = btn_o[c];
      if (s_c != cand_q) begin
        cand_d = s_c;
        cnt_d  = '0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        btn_d = cand_q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        cand_q <= RESET_LEVEL;
        cnt_q  <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i[c]};
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
      end
    end

    assign btn_nxt[c] = btn_d;
  end

  // Debounced levels and their edge pulses, all updated on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_o        <= {NUM_CH{RESET_LEVEL}};
      rise_o       <= '0;
      fall_o       <= '0;
      any_change_o <= 1'b0;
    end else begin
      btn_o        <= btn_nxt;
      rise_o       <= btn_nxt & ~btn_o;
      fall_o       <= ~btn_nxt & btn_o;
      any_change_o <= |(btn_nxt ^ btn_o);
    end
  end

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [NUM_CH-1:0] long_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_long
    logic [HOLD_W-1:0] hold_q;

    // Hold counter saturates at LONG_CYCLES so the pulse fires once per press
    always_ff @(posedge clk_i) begin
      if (rst_i || !btn_o[c]) begin
        hold_q <= '0;
      end else if (hold_q < HOLD_MAX) begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end

    assign long_hit[c] = btn_o[c] && (hold_q == (HOLD_MAX - HOLD_W'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      long_o <= '0;
    end else begin
      long_o <= long_hit;
    end
  end
`else
  assign long_o = '0;
`endif

endmodule
